// File: rtl/rag_csd_ctrl_master_if.sv
// AXI-Lite bus bundle between the accelerator control master and its register slave.
interface rag_csd_ctrl_master_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rag_csd_ctrl_master.sv
// Sequences one accelerator run over AXI-Lite: program top_k/metric, start,
// poll busy high, clear start, poll busy low, then report done/error.
module rag_csd_ctrl_master #(
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned MAX_POLLS = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cfg_top_k,
    input  logic [1:0]                    cfg_metric,
    rag_csd_ctrl_master_if.master         m_axil,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [31:0]                   last_status
);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_TOPK   = 3'd1;
    localparam logic [2:0] S_WR_METRIC = 3'd2;
    localparam logic [2:0] S_WR_START  = 3'd3;
    localparam logic [2:0] S_POLL_BUSY = 3'd4;
    localparam logic [2:0] S_WR_CLEAR  = 3'd5;
    localparam logic [2:0] S_POLL_IDLE = 3'd6;
    localparam logic [2:0] S_FINISH    = 3'd7;

    logic [2:0]    state;
    logic          txn_on;
    logic [31:0]   top_k_q;
    logic [1:0]    metric_q;
    logic [PW-1:0] poll_cnt;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   nxt_addr;
    logic [31:0]   nxt_data;

    logic aw_fin, w_fin, b_hs, r_hs, exit_poll, poll_last;

    assign cmd_ready = (state == S_IDLE);

    // A channel counts as finished if it already handshook or handshakes this cycle.
    assign aw_fin    = !m_axil.awvalid || m_axil.awready;
    assign w_fin     = !m_axil.wvalid || m_axil.wready;
    assign b_hs      = m_axil.bvalid && m_axil.bready;
    assign r_hs      = m_axil.rvalid && m_axil.rready;
    assign exit_poll = (state == S_POLL_BUSY) ? m_axil.rdata[0] : !m_axil.rdata[0];
    assign poll_last = (poll_cnt == PW'(MAX_POLLS - 1));

    always_comb begin
        nxt_addr = 32'h0000_0000;
        nxt_data = 32'h0000_0000;
        case (state)
            S_WR_TOPK:   begin nxt_addr = 32'h0000_0004; nxt_data = top_k_q; end
            S_WR_METRIC: begin nxt_addr = 32'h0000_0008; nxt_data = {30'd0, metric_q}; end
            S_WR_START:  begin nxt_addr = 32'h0000_0000; nxt_data = 32'h0000_0001; end
            default:     begin nxt_addr = 32'h0000_0000; nxt_data = 32'h0000_0000; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            txn_on         <= 1'b0;
            top_k_q        <= '0;
            metric_q       <= '0;
            poll_cnt       <= '0;
            gap_cnt        <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 2'd0;
            last_status    <= '0;
            m_axil.awvalid <= 1'b0;
            m_axil.awaddr  <= '0;
            m_axil.wvalid  <= 1'b0;
            m_axil.wdata   <= '0;
            m_axil.bready  <= 1'b0;
            m_axil.arvalid <= 1'b0;
            m_axil.araddr  <= '0;
            m_axil.rready  <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            if (m_axil.awvalid && m_axil.awready) m_axil.awvalid <= 1'b0;
            if (m_axil.wvalid && m_axil.wready)   m_axil.wvalid  <= 1'b0;
            if (txn_on && !m_axil.bready && (m_axil.awvalid || m_axil.wvalid) && aw_fin && w_fin)
                m_axil.bready <= 1'b1;
            if (m_axil.arvalid && m_axil.arready) begin
                m_axil.arvalid <= 1'b0;
                m_axil.rready  <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        top_k_q  <= cfg_top_k;
                        metric_q <= cfg_metric;
                        err_code <= 2'd0;
                        state    <= S_WR_TOPK;
                    end
                end

                S_WR_TOPK, S_WR_METRIC, S_WR_START, S_WR_CLEAR: begin
                    if (!txn_on) begin
                        txn_on         <= 1'b1;
                        m_axil.awvalid <= 1'b1;
                        m_axil.wvalid  <= 1'b1;
                        m_axil.awaddr  <= nxt_addr;
                        m_axil.wdata   <= nxt_data;
                    end else if (b_hs) begin
                        m_axil.bready <= 1'b0;
                        txn_on        <= 1'b0;
                        poll_cnt      <= '0;
                        if (m_axil.bresp != 2'd0) begin
                            err_code <= 2'd1;
                            state    <= S_FINISH;
                        end else begin
                            case (state)
                                S_WR_TOPK:   state <= S_WR_METRIC;
                                S_WR_METRIC: state <= S_WR_START;
                                S_WR_START:  state <= S_POLL_BUSY;
                                default:     state <= (err_code == 2'd2) ? S_FINISH : S_POLL_IDLE;
                            endcase
                        end
                    end
                end

                S_POLL_BUSY, S_POLL_IDLE: begin
                    if (!txn_on) begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end else begin
                            txn_on         <= 1'b1;
                            m_axil.arvalid <= 1'b1;
                            m_axil.araddr  <= 32'h0000_000C;
                        end
                    end else if (r_hs) begin
                        m_axil.rready <= 1'b0;
                        last_status   <= m_axil.rdata;
                        if (m_axil.rresp != 2'd0) begin
                            err_code <= 2'd1;
                            txn_on   <= 1'b0;
                            state    <= S_FINISH;
                        end else if (exit_poll || poll_last) begin
                            // A timeout in the busy phase still clears start before finishing.
                            if (!exit_poll) err_code <= 2'd2;
                            txn_on <= 1'b0;
                            state  <= (state == S_POLL_BUSY) ? S_WR_CLEAR : S_FINISH;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            if (POLL_GAP == 0) begin
                                m_axil.arvalid <= 1'b1;
                            end else begin
                                txn_on  <= 1'b0;
                                gap_cnt <= GW'(POLL_GAP - 1);
                            end
                        end
                    end
                end

                default: begin
                    done  <= 1'b1;
                    error <= (err_code != 2'd0);
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rag_csd_ctrl_master.sv
// Directed bench for rag_csd_ctrl_master with a scripted AXI-Lite register slave.
module tb_rag_csd_ctrl_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cfg_top_k;
    logic [1:0]  cfg_metric;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] last_status;

    always #5 clk = ~clk;

    rag_csd_ctrl_master_if bus ();

    rag_csd_ctrl_master #(.POLL_GAP(8), .MAX_POLLS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cfg_top_k   (cfg_top_k),
        .cfg_metric  (cfg_metric),
        .m_axil      (bus),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .last_status (last_status)
    );

    int   aw_dly, w_dly;
    logic slverr, never_busy, log_clr;

    int          aw_cnt, w_cnt, wr_n, rd_n, aw_hs, w_hs;
    logic        have_a, have_d;
    logic [31:0] pend_addr, pend_data;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_rdn  [16];

    // Slave: programmable ready skew, one write log entry per completed AW+W pair.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'd0;
            bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'd0;
            aw_cnt <= 0; w_cnt <= 0; wr_n <= 0; rd_n <= 0; aw_hs <= 0; w_hs <= 0;
            have_a <= 1'b0; have_d <= 1'b0; pend_addr <= '0; pend_data <= '0;
        end else if (log_clr) begin
            wr_n <= 0; rd_n <= 0; aw_hs <= 0; w_hs <= 0;
        end else begin
            if (bus.awvalid && !bus.awready) begin
                if (aw_cnt >= aw_dly) bus.awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end else begin
                bus.awready <= 1'b0; aw_cnt <= 0;
            end
            if (bus.wvalid && !bus.wready) begin
                if (w_cnt >= w_dly) bus.wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end else begin
                bus.wready <= 1'b0; w_cnt <= 0;
            end
            if (bus.awvalid && bus.awready) begin
                aw_hs <= aw_hs + 1; pend_addr <= bus.awaddr; have_a <= 1'b1;
            end
            if (bus.wvalid && bus.wready) begin
                w_hs <= w_hs + 1; pend_data <= bus.wdata; have_d <= 1'b1;
            end
            if (have_a && have_d && !bus.bvalid) begin
                if (wr_n < 16) begin
                    wr_addr[wr_n] <= pend_addr; wr_data[wr_n] <= pend_data; wr_rdn[wr_n] <= rd_n;
                end
                wr_n <= wr_n + 1;
                have_a <= 1'b0; have_d <= 1'b0;
                bus.bvalid <= 1'b1;
                bus.bresp  <= (slverr && pend_addr == 32'h8) ? 2'd2 : 2'd0;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;

            bus.arready <= bus.arvalid && !bus.arready;
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1;
                bus.rresp  <= 2'd0;
                bus.rdata  <= {16'hA5A5, 15'(rd_n), (!never_busy && rd_n == 1)};
                rd_n <= rd_n + 1;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    int          cyc = 0;
    int          proto_err = 0;
    int          hs_cyc, gap_n;
    int          gap_log [16];
    logic        p_aw, p_w, p_ar, ar_d, last_rd;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    // Monitor: valid/payload stability, single outstanding transaction, read-to-read gaps.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0; ar_d <= 1'b0; last_rd <= 1'b0;
        end else begin
            if (p_aw && (!bus.awvalid || bus.awaddr != p_awaddr)) proto_err <= proto_err + 1;
            if (p_w  && (!bus.wvalid  || bus.wdata  != p_wdata))  proto_err <= proto_err + 1;
            if (p_ar && (!bus.arvalid || bus.araddr != p_araddr)) proto_err <= proto_err + 1;
            if ((bus.awvalid || bus.wvalid || bus.bready) && (bus.arvalid || bus.rready))
                proto_err <= proto_err + 1;
            p_aw <= bus.awvalid && !bus.awready; p_awaddr <= bus.awaddr;
            p_w  <= bus.wvalid  && !bus.wready;  p_wdata  <= bus.wdata;
            p_ar <= bus.arvalid && !bus.arready; p_araddr <= bus.araddr;
            ar_d <= bus.arvalid;
            if (bus.rvalid && bus.rready) begin
                hs_cyc <= cyc; last_rd <= 1'b1;
            end else if (bus.awvalid) begin
                last_rd <= 1'b0;
            end
            if (bus.arvalid && !ar_d && last_rd && gap_n < 16) begin
                gap_log[gap_n] <= cyc - hs_cyc - 1;
                gap_n <= gap_n + 1;
            end
            if (log_clr) begin
                gap_n <= 0; last_rd <= 1'b0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_addr"}, wr_addr[i], a);
        chk({tag, "_data"}, wr_data[i], d);
    endtask

    task automatic clear_logs;
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] tk, input logic [1:0] m,
                       output logic er, output logic [1:0] code);
        logic got;
        clear_logs();
        cmd_valid = 1'b1; cfg_top_k = tk; cfg_metric = m;
        @(negedge clk);
        cmd_valid = 1'b0; cfg_top_k = 32'hDEAD_BEEF; cfg_metric = 2'd3;
        chk({tag, "_busy_not_ready"}, cmd_ready, 1'b0);
        got = 1'b0; er = 1'b0; code = 2'd0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1; er = error; code = err_code;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, got, 1'b1);
        @(negedge clk);
    endtask

    logic       r_er;
    logic [1:0] r_code;
    logic       reached;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cfg_top_k = '0; cfg_metric = '0;
        aw_dly = 0; w_dly = 0; slverr = 1'b0; never_busy = 1'b0; log_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
        chk("rst_flags", {done, error, err_code}, 0);
        chk("rst_payload", bus.awaddr | bus.wdata | bus.araddr | last_status, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // Nominal run
        run("nom", 32'd5, 2'd1, r_er, r_code);
        chk("nom_error", r_er, 1'b0);
        chk("nom_code", r_code, 2'd0);
        chk("nom_wr_n", wr_n, 4);
        chk_wr("nom_w0", 0, 32'h4, 32'd5);
        chk_wr("nom_w1", 1, 32'h8, 32'd1);
        chk_wr("nom_w2", 2, 32'h0, 32'd1);
        chk_wr("nom_w3", 3, 32'h0, 32'd0);
        chk("nom_clear_after_rd2", wr_rdn[3], 2);
        chk("nom_rd_n", rd_n, 3);
        chk("nom_last_status", last_status, 32'hA5A5_0004);
        chk("nom_gap_n", gap_n, 1);
        chk("nom_gap", gap_log[0], 8);

        // Ready skew: AW late, then W late
        aw_dly = 4; w_dly = 0;
        run("skewA", 32'd7, 2'd2, r_er, r_code);
        chk("skewA_aw_hs", aw_hs, 4);
        chk("skewA_w_hs", w_hs, 4);
        chk("skewA_wr_n", wr_n, 4);
        chk_wr("skewA_w0", 0, 32'h4, 32'd7);
        chk_wr("skewA_w1", 1, 32'h8, 32'd2);
        chk("skewA_error", r_er, 1'b0);
        aw_dly = 0; w_dly = 4;
        run("skewB", 32'd3, 2'd3, r_er, r_code);
        chk("skewB_aw_hs", aw_hs, 4);
        chk("skewB_w_hs", w_hs, 4);
        chk("skewB_wr_n", wr_n, 4);
        chk_wr("skewB_w1", 1, 32'h8, 32'd3);
        chk_wr("skewB_w2", 2, 32'h0, 32'd1);
        aw_dly = 0; w_dly = 0;

        // SLVERR on the metric write
        slverr = 1'b1;
        run("slverr", 32'd6, 2'd2, r_er, r_code);
        chk("slverr_error", r_er, 1'b1);
        chk("slverr_code", r_code, 2'd1);
        chk("slverr_wr_n", wr_n, 2);
        chk("slverr_rd_n", rd_n, 0);
        slverr = 1'b0;

        // Poll timeout: busy never seen
        never_busy = 1'b1;
        run("tmo", 32'd8, 2'd0, r_er, r_code);
        chk("tmo_error", r_er, 1'b1);
        chk("tmo_code", r_code, 2'd2);
        chk("tmo_rd_n", rd_n, 4);
        chk("tmo_wr_n", wr_n, 4);
        chk_wr("tmo_clear", 3, 32'h0, 32'd0);
        chk("tmo_clear_after_rd4", wr_rdn[3], 4);
        chk("tmo_gap_n", gap_n, 3);
        chk("tmo_gap2", gap_log[2], 8);
        repeat (3) @(negedge clk);
        chk("tmo_code_held", err_code, 2'd2);
        never_busy = 1'b0;

        // Reset while the idle-phase read address is pending
        clear_logs();
        cmd_valid = 1'b1; cfg_top_k = 32'd9; cfg_metric = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wr_n == 4 && bus.arvalid) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_reached", reached, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
        chk("mid_flags", {done, error, err_code}, 0);
        chk("mid_payload", bus.awaddr | bus.wdata | bus.araddr | last_status, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_cmd_ready", cmd_ready, 1'b1);
        run("post", 32'd11, 2'd0, r_er, r_code);
        chk("post_error", r_er, 1'b0);
        chk_wr("post_w0", 0, 32'h4, 32'd11);
        chk("post_wr_n", wr_n, 4);

        chk("protocol", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rag_csd_ctrl_master.md
RAG_CSD_CTRL_MASTER -- requirements
Module: rag_csd_ctrl_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 8: idle cycles between a status read completing and the next status read; 0 means back-to-back.
REQ-002 SHALL have parameter MAX_POLLS, default 1024: maximum status reads allowed per poll phase.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  request one accelerator run.
- cmd_ready  out  1  master idle; a run is accepted when cmd_valid && cmd_ready.
- cfg_top_k  in  32  top-k value, sampled on accept.
- cfg_metric  in  2  similarity metric, sampled on accept.
- m_axil_awvalid/awready/awaddr[31:0]  out/in/out  AXI-Lite write address.
- m_axil_wvalid/wready/wdata[31:0]  out/in/out  AXI-Lite write data.
- m_axil_bvalid/bready/bresp[1:0]  in/out/in  AXI-Lite write response.
- m_axil_arvalid/arready/araddr[31:0]  out/in/out  AXI-Lite read address.
- m_axil_rvalid/rready/rdata[31:0]/rresp[1:0]  in/out/in/in  AXI-Lite read data.
- done  out  1  one-cycle pulse at run end, success or failure.
- error  out  1  valid with done; 1 = run failed.
- err_code  out  2  0 none, 1 bad response, 2 timeout; held until next accept.
- last_status  out  32  rdata of most recent status read.

Function
REQ-004 Register map: 0x00 control (bit0 start), 0x04 top_k, 0x08 metric (bits 1:0, upper wdata bits 0), 0x0C status (bit0 busy).
REQ-005 Phase order after accept:
- WR_TOPK: 0x04 <- cfg_top_k.
- WR_METRIC: 0x08 <- cfg_metric.
- WR_START: 0x00 <- 1.
- POLL_BUSY: read 0x0C until bit0=1.
- WR_CLEAR: 0x00 <- 0.
- POLL_IDLE: read 0x0C until bit0=0.
- FINISH: done pulse, then IDLE.
REQ-006 Write transaction:
- awvalid and wvalid assert in the same cycle.
- Each is held until its own ready handshake; they complete independently and in either order.
- After both complete, bready=1 until bvalid.
- Transaction ends on the bvalid && bready cycle.
REQ-007 Read transaction:
- arvalid held until arready.
- Then rready=1 until rvalid.
- Transaction ends on the rvalid && rready cycle; rdata is captured into last_status that cycle.
REQ-008 Only one AXI-Lite transaction is outstanding at any time; a valid signal never deasserts before its handshake.
REQ-009 Address and data are stable while the corresponding valid is high.
REQ-010 Next transaction issues no earlier than the cycle after the previous one ends; POLL_GAP applies only between consecutive status reads.
REQ-011 Timeout: a per-phase poll counter resets on entry to each poll phase.
- Counter reaching MAX_POLLS without the exit condition sets err_code=2.
- Then perform WR_CLEAR (only if not already cleared), then FINISH with error=1.
REQ-012 Bad response: bresp!=0 or rresp!=0 on any transaction sets err_code=1 and goes directly to FINISH with error=1; no further transactions.
REQ-013 Response-error detection takes priority over timeout in the same cycle.
REQ-014 cmd_ready=1 only in IDLE; cmd_valid outside IDLE is ignored.
REQ-015 cfg inputs changing after accept do not affect the current run.
REQ-016 Latency with all slave ready/valid signals tied high in the cycle after assertion: ≤3 cycles per transaction.

Reset
REQ-017 While rst_n=0, all of the following are 0: valid outputs, bready, rready, done, error, err_code, last_status, and all addresses and data.
- State is IDLE; cmd_ready=1 from the first cycle after release.
REQ-018 Reset asserted mid-transaction abandons it immediately; no valid is held across reset.

Verification
REQ-019 Nominal: top_k=5, metric=1; slave returns busy=1 on read 2, busy=0 on read 3 after clear.
- Expect writes in order 0x04=5, 0x08=1, 0x00=1, 0x00=0.
- done=1, error=0, last_status bit0=0.
REQ-020 Ready skew: awready 4 cycles after wready, then awready before wready.
- Each channel handshakes exactly once; no duplicate writes.
REQ-021 SLVERR: bresp=2 on the 0x08 write.
- No write to 0x00; done with error=1, err_code=1.
REQ-022 Timeout: MAX_POLLS=4, busy never 1.
- Exactly 4 reads of 0x0C, then write 0x00=0, then done with err_code=2.
REQ-023 POLL_GAP=8: measure araddr assertions.
- Exactly 8 idle cycles between an rvalid handshake and the next arvalid.
REQ-024 Reset during POLL_IDLE with arvalid high.
- All outputs 0 next cycle; a new cmd is accepted after release and runs from WR_TOPK.
